// File: rtl/ps2_mouse_packet_ctrl.sv
// PS/2 mouse receive path: clock filter, 11-bit frame deserialiser, 3-byte packet assembly
// and clamped cursor/button state for the mouse_controller register file.
module ps2_mouse_packet_ctrl #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned POS_W          = 10,
  parameter int unsigned X_MAX          = 639,
  parameter int unsigned Y_MAX          = 479
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  input  logic             enable,
  input  logic             clr_pos,
  input  logic             pkt_ack,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic [2:0]       buttons,
  output logic             pkt_valid,
  output logic             new_pkt,
  output logic             err_pulse,
  output logic [7:0]       err_cnt
);

  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SW  = POS_W + 2;
  localparam logic [POS_W-1:0]     X_CTR = POS_W'(X_MAX / 2);
  localparam logic [POS_W-1:0]     Y_CTR = POS_W'(Y_MAX / 2);
  localparam logic signed [SW-1:0] X_LIM = SW'(X_MAX);
  localparam logic signed [SW-1:0] Y_LIM = SW'(Y_MAX);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic           r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic [FCW-1:0] r_fcnt;
  logic           r_filt;
  logic           w_flip, w_fall;
  state_e         r_state, w_state_next;
  logic           w_shift_en, w_par_en, w_start, w_byte_done;
  logic [2:0]     r_bit_cnt;
  logic [7:0]     r_shift;
  logic           r_parity;
  logic           w_byte_ok, w_sync_err, w_err;
  logic [WDW-1:0] r_wdog;
  logic           w_active, w_abort;
  logic [1:0]     r_idx;
  logic [6:0]     r_stat;  // {ovf_y, ovf_x, sgn_y, sgn_x, btn[2:0]}
  logic [7:0]     r_dx, r_dy;
  logic           r_upd;
  logic signed [8:0]    w_dx9, w_dy9;
  logic signed [SW-1:0] w_sum_x, w_sum_y;
  logic [POS_W-1:0]     w_new_x, w_new_y;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      {r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2} <= '1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Flip after FILTER_LEN consecutive samples disagreeing with the filtered level.
  assign w_flip = (r_clk_s2 != r_filt) && (r_fcnt == FCW'(FILTER_LEN - 1));
  assign w_fall = w_flip && r_filt;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_filt <= 1'b1;
      r_fcnt <= '0;
    end else if (r_clk_s2 == r_filt) begin
      r_fcnt <= '0;
    end else if (w_flip) begin
      r_filt <= r_clk_s2;
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + 1'b1;
    end
  end

  assign w_active = (r_state != StIdle) || (r_idx != 2'd0);
  assign w_abort  = w_active && !w_fall && (r_wdog == WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (!enable || w_abort) begin
      w_state_next = StIdle;
    end else if (w_fall) begin
      unique case (r_state)
        StIdle:   if (!r_dat_s2) w_state_next = StData;
        StData:   if (r_bit_cnt == 3'd7) w_state_next = StParity;
        StParity: w_state_next = StStop;
        StStop:   w_state_next = StIdle;
      endcase
    end
  end

  always_comb begin
    w_start     = enable && w_fall && (r_state == StIdle) && !r_dat_s2;
    w_shift_en  = enable && w_fall && (r_state == StData);
    w_par_en    = enable && w_fall && (r_state == StParity);
    w_byte_done = enable && w_fall && (r_state == StStop);
  end

  assign w_byte_ok  = w_byte_done && r_dat_s2 && (^{r_shift, r_parity});
  assign w_sync_err = w_byte_ok && (r_idx == 2'd0) && !r_shift[3];
  assign w_err      = (w_byte_done && !w_byte_ok) || w_sync_err;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_wdog    <= '0;
    end else begin
      if (w_start) r_bit_cnt <= '0;
      else if (w_shift_en) r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_shift_en) r_shift <= {r_dat_s2, r_shift[7:1]};
      if (w_par_en) r_parity <= r_dat_s2;
      if (!enable || w_fall || !w_active || w_abort) r_wdog <= '0;
      else r_wdog <= r_wdog + 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_idx  <= '0;
      r_stat <= '0;
      r_dx   <= '0;
      r_dy   <= '0;
      r_upd  <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      if (!enable || w_abort || w_err) begin
        r_idx <= '0;
      end else if (w_byte_ok) begin
        unique case (r_idx)
          2'd0: begin
            r_stat <= {r_shift[7:4], r_shift[2:0]};
            r_idx  <= 2'd1;
          end
          2'd1: begin
            r_dx  <= r_shift;
            r_idx <= 2'd2;
          end
          default: begin
            r_dy  <= r_shift;
            r_idx <= 2'd0;
            r_upd <= 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    w_dx9   = r_stat[5] ? 9'sd0 : $signed({r_stat[3], r_dx});
    w_dy9   = r_stat[6] ? 9'sd0 : $signed({r_stat[4], r_dy});
    w_sum_x = $signed({2'b00, pos_x}) + {{(SW-9){w_dx9[8]}}, w_dx9};
    w_sum_y = $signed({2'b00, pos_y}) - {{(SW-9){w_dy9[8]}}, w_dy9};
    if (w_sum_x[SW-1])      w_new_x = '0;
    else if (w_sum_x > X_LIM) w_new_x = X_LIM[POS_W-1:0];
    else                      w_new_x = w_sum_x[POS_W-1:0];
    if (w_sum_y[SW-1])      w_new_y = '0;
    else if (w_sum_y > Y_LIM) w_new_y = Y_LIM[POS_W-1:0];
    else                      w_new_y = w_sum_y[POS_W-1:0];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pos_x     <= X_CTR;
      pos_y     <= Y_CTR;
      buttons   <= '0;
      pkt_valid <= 1'b0;
      new_pkt   <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (clr_pos) begin
        pos_x <= X_CTR;
        pos_y <= Y_CTR;
      end else if (r_upd) begin
        pos_x <= w_new_x;
        pos_y <= w_new_y;
      end
      if (r_upd) buttons <= r_stat[2:0];
      pkt_valid <= r_upd;
      if (r_upd) new_pkt <= 1'b1;
      else if (pkt_ack) new_pkt <= 1'b0;
      err_pulse <= w_err;
      if (w_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_mouse_packet_ctrl.sv
// Scoreboard bench: a byte-level reference model queues expected updates/errors while a
// forked monitor pops and compares on every pkt_valid / err_pulse.
module tb_ps2_mouse_packet_ctrl;
  localparam int XM = 639;
  localparam int YM = 479;

  logic       ACLK = 1'b0, ARESETN = 1'b0;
  logic       ps2_clk = 1'b1, ps2_data = 1'b1, enable = 1'b1, clr_pos = 1'b0, pkt_ack = 1'b0;
  logic [9:0] pos_x, pos_y;
  logic [2:0] buttons;
  logic       pkt_valid, new_pkt, err_pulse;
  logic [7:0] err_cnt;

  ps2_mouse_packet_ctrl #(
    .FILTER_LEN(4), .TIMEOUT_CYCLES(2000), .POS_W(10), .X_MAX(XM), .Y_MAX(YM)
  ) u_dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .enable(enable), .clr_pos(clr_pos), .pkt_ack(pkt_ack), .pos_x(pos_x), .pos_y(pos_y),
    .buttons(buttons), .pkt_valid(pkt_valid), .new_pkt(new_pkt), .err_pulse(err_pulse),
    .err_cnt(err_cnt)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {int x; int y; int btn;} upd_t;
  upd_t exp_q[$];
  int   err_q[$];
  int   tests = 0, fails = 0;

  // Reference model state
  int         m_x, m_y, m_idx, m_err;
  logic [7:0] m_status, m_b1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int clamp(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic model_err();
    m_err = (m_err < 255) ? m_err + 1 : 255;
    err_q.push_back(m_err);
    m_idx = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good, input bit clr);
    int   dx, dy;
    upd_t u;
    if (!good) begin
      model_err();
    end else if (m_idx == 0) begin
      if (!b[3]) model_err();
      else begin m_status = b; m_idx = 1; end
    end else if (m_idx == 1) begin
      m_b1 = b; m_idx = 2;
    end else begin
      dx = m_status[6] ? 0 : (m_status[4] ? int'(m_b1) - 256 : int'(m_b1));
      dy = m_status[7] ? 0 : (m_status[5] ? int'(b) - 256 : int'(b));
      if (clr) begin m_x = XM / 2; m_y = YM / 2; end
      else begin m_x = clamp(m_x + dx, XM); m_y = clamp(m_y - dy, YM); end
      u.x = m_x; u.y = m_y; u.btn = int'(m_status & 8'h07);
      exp_q.push_back(u);
      m_idx = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input int per);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = fr[i];
      repeat (per / 4) @(negedge ACLK);
      ps2_clk = 1'b0;
      repeat (per / 2) @(negedge ACLK);
      ps2_clk = 1'b1;
      repeat (per / 4) @(negedge ACLK);
    end
  endtask

  // Model first: the DUT output can appear before send_byte returns.
  task automatic byte_tx(input logic [7:0] b, input bit bad, input int per, input bit clr);
    model_byte(b, !bad, clr);
    send_byte(b, bad, per);
  endtask

  task automatic pkt(input logic [7:0] b0, b1, b2, input int per, input bit clr);
    byte_tx(b0, 1'b0, per, 1'b0);
    byte_tx(b1, 1'b0, per, 1'b0);
    if (clr) clr_pos = 1'b1;
    byte_tx(b2, 1'b0, per, clr);
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && (exp_q.size() + err_q.size()) != 0; i++) @(negedge ACLK);
    check("drain pending events", exp_q.size() + err_q.size(), 0);
    exp_q.delete();
    err_q.delete();
    repeat (5) @(negedge ACLK);
    clr_pos = 1'b0;
    @(negedge ACLK);
  endtask

  task automatic do_reset();
    ARESETN = 1'b0; clr_pos = 1'b0; pkt_ack = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    m_x = XM / 2; m_y = YM / 2; m_idx = 0; m_err = 0;
    exp_q.delete(); err_q.delete();
    repeat (3) @(negedge ACLK);
    check("reset pos_x", int'(pos_x), XM / 2);
    check("reset pos_y", int'(pos_y), YM / 2);
    check("reset buttons", int'(buttons), 0);
    check("reset flags", int'({pkt_valid, new_pkt, err_pulse}), 0);
    check("reset err_cnt", int'(err_cnt), 0);
    ARESETN = 1'b1;
    repeat (3) @(negedge ACLK);
  endtask

  task automatic monitor();
    upd_t e;
    int   ec;
    forever begin
      @(negedge ACLK);
      if (ARESETN) begin
        if (pkt_valid) begin
          if (exp_q.size() == 0) check("unexpected pkt_valid", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("pkt pos_x", int'(pos_x), e.x);
            check("pkt pos_y", int'(pos_y), e.y);
            check("pkt buttons", int'(buttons), e.btn);
            check("pkt new_pkt", int'(new_pkt), 1);
          end
        end
        if (err_pulse) begin
          if (err_q.size() == 0) check("unexpected err_pulse", 1, 0);
          else begin
            ec = err_q.pop_front();
            check("err err_cnt", int'(err_cnt), ec);
          end
        end
      end
    end
  endtask

  initial begin
    logic [7:0] rb0, rb1, rb2;
    fork
      monitor();
    join_none

    // Basic packet, sticky flag and acknowledge
    do_reset();
    pkt(8'h09, 8'h0A, 8'hFB, 200, 1'b0);
    drain();
    check("new_pkt held", int'(new_pkt), 1);
    pkt_ack = 1'b1; @(negedge ACLK); pkt_ack = 1'b0; @(negedge ACLK);
    check("new_pkt after ack", int'(new_pkt), 0);

    // Large negative moves clamp at both edges; clr_pos alone recentres
    do_reset();
    pkt(8'h38, 8'h00, 8'h00, 200, 1'b0);
    pkt(8'h38, 8'h00, 8'h00, 200, 1'b0);
    drain();
    check("clamp pos_x", int'(pos_x), 0);
    check("clamp pos_y", int'(pos_y), YM);
    clr_pos = 1'b1; @(negedge ACLK); clr_pos = 1'b0; @(negedge ACLK);
    check("clr_pos x", int'(pos_x), 319);
    check("clr_pos y", int'(pos_y), 239);

    // Parity error inside a packet
    do_reset();
    byte_tx(8'h08, 1'b0, 200, 1'b0);
    byte_tx(8'h0A, 1'b1, 200, 1'b0);
    pkt(8'h08, 8'h01, 8'h00, 200, 1'b0);
    drain();
    check("parity err_cnt", int'(err_cnt), 1);
    check("after parity pos_x", int'(pos_x), 320);

    // Sync error on first byte
    do_reset();
    byte_tx(8'h00, 1'b0, 200, 1'b0);
    pkt(8'h08, 8'h05, 8'h05, 200, 1'b0);
    drain();
    check("sync err_cnt", int'(err_cnt), 1);
    check("after sync pos", int'(pos_x) * 1000 + int'(pos_y), 324234);

    // Mid-packet timeout discards partial packet silently
    do_reset();
    byte_tx(8'h08, 1'b0, 200, 1'b0);
    byte_tx(8'h10, 1'b0, 200, 1'b0);
    repeat (3000) @(negedge ACLK);
    m_idx = 0;
    pkt(8'h08, 8'h02, 8'h00, 200, 1'b0);
    drain();
    check("timeout pos_x", int'(pos_x), 321);
    check("timeout err_cnt", int'(err_cnt), 0);

    // X overflow forces dx=0; clr_pos coincident with update wins on position
    do_reset();
    pkt(8'h48, 8'h7F, 8'h01, 200, 1'b0);
    drain();
    check("ovf pos", int'(pos_x) * 1000 + int'(pos_y), 319238);
    pkt(8'h48, 8'h7F, 8'h01, 200, 1'b1);
    drain();
    check("ovf clr pos", int'(pos_x) * 1000 + int'(pos_y), 319239);

    // Randomised packets with occasional sync and parity faults
    do_reset();
    for (int p = 0; p < 5; p++) begin
      rb0 = 8'($urandom) | 8'h08;
      if ($urandom_range(0, 5) == 0) rb0[3] = 1'b0;
      rb1 = 8'($urandom);
      rb2 = 8'($urandom);
      byte_tx(rb0, $urandom_range(0, 9) == 0, 60, 1'b0);
      byte_tx(rb1, $urandom_range(0, 9) == 0, 60, 1'b0);
      byte_tx(rb2, $urandom_range(0, 9) == 0, 60, 1'b0);
    end
    drain();
    check("random err_cnt", int'(err_cnt), m_err);
    check("random pos_x", int'(pos_x), m_x);
    check("random pos_y", int'(pos_y), m_y);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
